// File: rtl/cache_trace_sim.sv
// cache_trace_sim: direct-mapped cache hit/miss classifier with running statistics.
// It watches one CPU access stream (instruction fetch or data memory).
// Each accepted access is classified one cycle later. A miss allocates the line.
// A flush invalidates one line per cycle.
// Optional build macro: CACHE_SIM_NO_WRITE_ALLOC_EN adds acc_we_i.
// With it, write misses are counted but do not allocate.
//
// state | meaning
// IDLE  | accepting accesses, classifying against the tag store
// FLUSH | walking every line from index 0 upward and clearing its valid bit
module cache_trace_sim #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 4,
  parameter int INDEX_W  = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              acc_valid_i,
  input  logic [ADDR_W-1:0] acc_addr_i,
`ifdef CACHE_SIM_NO_WRITE_ALLOC_EN
  input  logic              acc_we_i,
`endif
  output logic              acc_ready_o,
  input  logic              flush_i,
  output logic              res_valid_o,
  output logic              res_hit_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  acc_cnt_o,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [INDEX_W-1:0]   flush_idx;
  logic [LINES-1:0]     line_valid;
  logic [TAG_W-1:0]     tag_mem [LINES];

  logic [INDEX_W-1:0]   index;
  logic [TAG_W-1:0]     tag;
  logic                 lookup_hit;
  logic                 accept;
  logic                 alloc;
  logic                 flush_last;
  logic                 unused_offset;

  assign index         = acc_addr_i[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign tag           = acc_addr_i[ADDR_W-1:OFFSET_W+INDEX_W];
  assign unused_offset = ^acc_addr_i[OFFSET_W-1:0];

  // The tag store already holds the fill from the previous accepted access.
  // Back-to-back accesses to the same block therefore hit.
  assign lookup_hit = line_valid[index] && (tag_mem[index] == tag);
  assign accept     = acc_valid_i && acc_ready_o;
  assign flush_last = (flush_idx == INDEX_W'(LINES - 1));

`ifdef CACHE_SIM_NO_WRITE_ALLOC_EN
  assign alloc = accept && !lookup_hit && !acc_we_i;
`else
  assign alloc = accept && !lookup_hit;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake. Ready is held low while reset is asserted.
  // A flush request takes priority over a simultaneous access.
  always_comb begin
    state_nxt   = state;
    acc_ready_o = 1'b0;
    busy_o      = 1'b0;
    case (state)
      IDLE: begin
        acc_ready_o = rst_i && !flush_i;
        if (flush_i) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy_o = 1'b1;
        if (flush_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Flush line pointer, restarted at 0 on flush entry.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      flush_idx <= '0;
    end else if (state == IDLE) begin
      flush_idx <= '0;
    end else begin
      flush_idx <= flush_idx + 1'b1;
    end
  end

  // Line valid bits: cleared by reset or by the flush walk, set on allocation.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      line_valid <= '0;
    end else if (state == FLUSH) begin
      line_valid[flush_idx] <= 1'b0;
    end else if (alloc) begin
      line_valid[index] <= 1'b1;
    end
  end

  // Tag store. Its contents are meaningless until the matching valid bit is set.
  always_ff @(posedge clk_i) begin
    if (alloc) tag_mem[index] <= tag;
  end

  // Registered classification result, one pulse per accepted access.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      res_valid_o <= 1'b0;
      res_hit_o   <= 1'b0;
    end else begin
      res_valid_o <= accept;
      res_hit_o   <= accept && lookup_hit;
    end
  end

  // Saturating statistics. Each counter sticks at all-ones on its own.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_cnt_o  <= '0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (accept) begin
      if (acc_cnt_o != '1) acc_cnt_o <= acc_cnt_o + 1'b1;
      if (lookup_hit) begin
        if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 1'b1;
      end else begin
        if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_trace_sim.sv
// Testbench for cache_trace_sim.
// Directed cases plus a randomized access/flush stream.
// Results are compared with a line-array reference model.
// A second instance built with CNT_W=4 exercises counter saturation.
module tb_cache_trace_sim;

`ifdef CACHE_SIM_NO_WRITE_ALLOC_EN
  localparam bit NWA = 1'b1;
`else
  localparam bit NWA = 1'b0;
`endif
  localparam int CNT_MAX = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        acc_valid = 1'b0;
  logic [31:0] acc_addr = '0;
  logic        acc_we = 1'b0;
  logic        flush = 1'b0;
  logic        acc_ready, res_valid, res_hit, busy;
  logic [15:0] acc_cnt, hit_cnt, miss_cnt;

  logic        s_valid = 1'b0;
  logic [31:0] s_addr = '0;
  logic        s_we = 1'b0;
  logic        s_ready, s_res_valid, s_res_hit, s_busy;
  logic [3:0]  s_acc, s_hit, s_miss;

  int checks = 0;
  int errors = 0;

  bit          m_valid [16];
  int unsigned m_tag   [16];
  int          m_acc, m_hit, m_miss, m_flush_left;

  always #5 clk = ~clk;

  cache_trace_sim dut (
    .clk_i(clk), .rst_i(rst), .acc_valid_i(acc_valid), .acc_addr_i(acc_addr),
`ifdef CACHE_SIM_NO_WRITE_ALLOC_EN
    .acc_we_i(acc_we),
`endif
    .acc_ready_o(acc_ready), .flush_i(flush), .res_valid_o(res_valid),
    .res_hit_o(res_hit), .busy_o(busy), .acc_cnt_o(acc_cnt),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  cache_trace_sim #(.CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .acc_valid_i(s_valid), .acc_addr_i(s_addr),
`ifdef CACHE_SIM_NO_WRITE_ALLOC_EN
    .acc_we_i(s_we),
`endif
    .acc_ready_o(s_ready), .flush_i(1'b0), .res_valid_o(s_res_valid),
    .res_hit_o(s_res_hit), .busy_o(s_busy), .acc_cnt_o(s_acc),
    .hit_cnt_o(s_hit), .miss_cnt_o(s_miss)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  task automatic model_reset();
    foreach (m_valid[i]) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
    end
    m_acc = 0; m_hit = 0; m_miss = 0; m_flush_left = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, acc_ready}, 0);
    check({tag, "_rv"},    {31'd0, res_valid}, 0);
    check({tag, "_hit"},   {31'd0, res_hit}, 0);
    check({tag, "_busy"},  {31'd0, busy}, 0);
    check({tag, "_acc"},   {16'd0, acc_cnt}, 0);
    check({tag, "_miss"},  {16'd0, miss_cnt}, 0);
  endtask

  // Assert reset with a request pending, confirm quiet outputs, and release.
  // Returns at posedge + 1.
  task automatic do_reset();
    rst = 1'b0; acc_valid = 1'b1; flush = 1'b0; s_valid = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    acc_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus. It is called and returns at posedge + 1.
  task automatic step(input bit v, input logic [31:0] a, input bit f, input bit w,
                      output bit accepted);
    bit exp_ready, exp_hit;
    int idx;
    int unsigned tg;
    acc_valid = v; acc_addr = a; flush = f; acc_we = w;
    #1;
    exp_ready = (m_flush_left == 0) && !f;
    check("ready", {31'd0, acc_ready}, {31'd0, exp_ready});
    @(posedge clk);
    accepted = v && exp_ready;
    exp_hit  = 1'b0;
    if (accepted) begin
      idx     = int'((a >> 4) & 32'hF);
      tg      = a >> 8;
      exp_hit = m_valid[idx] && (m_tag[idx] == tg);
      m_acc   = sat(m_acc, CNT_MAX);
      if (exp_hit) m_hit = sat(m_hit, CNT_MAX);
      else begin
        m_miss = sat(m_miss, CNT_MAX);
        if (!(NWA && w)) begin
          m_valid[idx] = 1'b1;
          m_tag[idx]   = tg;
        end
      end
    end
    if (m_flush_left > 0) m_flush_left--;
    else if (f) begin
      m_flush_left = 16;
      foreach (m_valid[i]) m_valid[i] = 1'b0;
    end
    #1;
    check("res_valid", {31'd0, res_valid}, {31'd0, accepted});
    if (accepted) check("res_hit", {31'd0, res_hit}, {31'd0, exp_hit});
    check("busy", {31'd0, busy}, (m_flush_left > 0) ? 32'd1 : 32'd0);
    check("acc_cnt",  {16'd0, acc_cnt},  m_acc);
    check("hit_cnt",  {16'd0, hit_cnt},  m_hit);
    check("miss_cnt", {16'd0, miss_cnt}, m_miss);
  endtask

  task automatic idle_cycle();
    bit acc;
    step(1'b0, 32'h0, 1'b0, 1'b0, acc);
  endtask

  initial begin
    bit          acc;
    bit          pend;
    bit          v, f, w;
    logic [31:0] a;
    int          busy_cycles;

    do_reset();

    // Counter saturation on the CNT_W=4 instance: 20 misses to distinct tags.
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_addr  = 32'(i) << 8;
      @(posedge clk);
      #1;
      check("sat_rv",   {31'd0, s_res_valid}, 1);
      check("sat_hit",  {31'd0, s_res_hit}, 0);
      check("sat_miss", {28'd0, s_miss}, (i + 1 > 15) ? 15 : i + 1);
      check("sat_acc",  {28'd0, s_acc},  (i + 1 > 15) ? 15 : i + 1);
    end
    s_valid = 1'b0;
    check("sat_hit_cnt", {28'd0, s_hit}, 0);

    // Miss followed by a hit in the same block.
    do_reset();
    step(1'b1, 32'h0, 1'b0, 1'b0, acc);
    check("t1_first_hit", {31'd0, res_hit}, 0);
    step(1'b1, 32'h4, 1'b0, 1'b0, acc);
    check("t1_second_hit", {31'd0, res_hit}, 1);
    idle_cycle();
    check("t1_acc",  {16'd0, acc_cnt}, 2);
    check("t1_hit",  {16'd0, hit_cnt}, 1);
    check("t1_miss", {16'd0, miss_cnt}, 1);

    // Conflict eviction on index 0.
    do_reset();
    step(1'b1, 32'h0,   1'b0, 1'b0, acc);
    step(1'b1, 32'h100, 1'b0, 1'b0, acc);
    step(1'b1, 32'h0,   1'b0, 1'b0, acc);
    check("t2_hit_last", {31'd0, res_hit}, 0);
    check("t2_acc",  {16'd0, acc_cnt}, 3);
    check("t2_hit",  {16'd0, hit_cnt}, 0);
    check("t2_miss", {16'd0, miss_cnt}, 3);

    // Sweep all 16 lines twice back to back.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 16; i++) begin
        step(1'b1, 32'(i) << 4, 1'b0, 1'b0, acc);
        check("t3_hit", {31'd0, res_hit}, {31'd0, 1'(r)});
      end
    check("t3_hit_cnt",  {16'd0, hit_cnt}, 16);
    check("t3_miss_cnt", {16'd0, miss_cnt}, 16);

    // Flush collides with an access. The requester holds it.
    // A second flush pulse mid-walk must not restart the flush.
    step(1'b1, 32'h0, 1'b1, 1'b0, acc);
    check("t4_res_valid_on_flush", {31'd0, res_valid}, 0);
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    acc = 1'b0;
    for (int i = 0; i < 24 && !acc; i++) begin
      step(1'b1, 32'h0, (i == 5), 1'b0, acc);
      if (!acc && busy === 1'b1) busy_cycles++;
    end
    check("t4_accepted", {31'd0, acc}, 1);
    check("t4_busy_cycles", busy_cycles, 16);
    check("t4_hit_after_flush", {31'd0, res_hit}, 0);
    check("t4_acc",  {16'd0, acc_cnt}, 33);
    check("t4_miss", {16'd0, miss_cnt}, 17);

    // Reset in the middle of a flush.
    step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    idle_cycle();
    idle_cycle();
    check("t5_busy_before", {31'd0, busy}, 1);
    rst = 1'b0;
    #1;
    check("t5_busy_rst", {31'd0, busy}, 0);
    check("t5_acc_rst",  {16'd0, acc_cnt}, 0);
    do_reset();

    // Reset while a result pulse is showing.
    step(1'b1, 32'h20, 1'b0, 1'b0, acc);
    check("t6_rv_before", {31'd0, res_valid}, 1);
    rst = 1'b0;
    acc_valid = 1'b0;
    #1;
    check("t6_rv_rst", {31'd0, res_valid}, 0);
    do_reset();

`ifdef CACHE_SIM_NO_WRITE_ALLOC_EN
    // A write miss must not allocate the line.
    step(1'b1, 32'h40, 1'b0, 1'b1, acc);
    check("t7_wr_hit", {31'd0, res_hit}, 0);
    step(1'b1, 32'h40, 1'b0, 1'b0, acc);
    check("t7_rd1_hit", {31'd0, res_hit}, 0);
    step(1'b1, 32'h40, 1'b0, 1'b0, acc);
    check("t7_rd2_hit", {31'd0, res_hit}, 1);
    do_reset();
`endif

    // Random stream. A request that is not accepted is held.
    pend = 1'b0;
    v = 1'b0; w = 1'b0; a = '0;
    for (int n = 0; n < 600; n++) begin
      if (!pend) begin
        v = ($urandom_range(0, 3) != 0);
        a = (32'($urandom_range(0, 1)) << 31) | (32'($urandom_range(0, 3)) << 8) |
            (32'($urandom_range(0, 15)) << 4) | 32'($urandom_range(0, 15));
        w = 1'($urandom_range(0, 1));
      end
      f = ($urandom_range(0, 39) == 0);
      step(v, a, f, w, acc);
      pend = v && !acc;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
